// File: rtl/host_ctrl_packetizer.sv
// Builds fixed 6-word control frames (trigin / slowme / ratein) on an AXI-stream
// master, with one pending slot per request type and a forced inter-frame gap.
module host_ctrl_packetizer #(
  parameter logic [31:0] HDR0       = 32'h1111_6843,
  parameter logic [31:0] HDR1       = 32'h1654_4502,
  parameter logic [31:0] HDR2       = 32'h8F54_0000,
  parameter logic [15:0] ETH_TYPE   = 16'h005C,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic        TrigReq,
  input  logic        SlowReq,
  input  logic [31:0] SlowFill,
  input  logic        RateReq,
  input  logic [31:0] RateDelay,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        Busy,
  output logic [15:0] FramesSent,
  output logic [7:0]  DropCount
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  typedef enum logic [1:0] {T_TRIG, T_SLOW, T_RATE} ftype_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      r_state, w_state_nx;
  ftype_t      r_type;
  logic        r_trig_pend, r_slow_pend, r_rate_pend;
  logic [31:0] r_slow_fill, r_rate_delay, r_payload;
  logic [2:0]  r_idx;
  logic [7:0]  r_gap_cnt;
  logic [15:0] r_frames;
  logic [7:0]  r_drops;

  logic        w_sel_trig, w_sel_slow, w_sel_rate, w_sel_any;
  logic        w_hs, w_last_hs, w_gap_done;
  logic [1:0]  w_drop_inc;
  logic [8:0]  w_drop_sum;
  logic [15:0] w_tag_hi;
  logic [31:0] w_tag_lo;

  assign w_sel_trig = (r_state == S_IDLE) && r_trig_pend;
  assign w_sel_slow = (r_state == S_IDLE) && !r_trig_pend && r_slow_pend;
  assign w_sel_rate = (r_state == S_IDLE) && !r_trig_pend && !r_slow_pend && r_rate_pend;
  assign w_sel_any  = w_sel_trig || w_sel_slow || w_sel_rate;
  assign w_hs       = (r_state == S_SEND) && m_axis_tready;
  assign w_last_hs  = w_hs && (r_idx == 3'd5);
  assign w_gap_done = (r_gap_cnt == GAP_LAST);

  // A pulse that lands on the edge its flag is being consumed re-arms the
  // flag for a later frame and is not counted as a drop.
  assign w_drop_inc = {1'b0, TrigReq && r_trig_pend && !w_sel_trig}
                    + {1'b0, SlowReq && r_slow_pend && !w_sel_slow}
                    + {1'b0, RateReq && r_rate_pend && !w_sel_rate};
  assign w_drop_sum = {1'b0, r_drops} + {7'b0, w_drop_inc};

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) r_state <= S_IDLE;
    else                r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_sel_any) w_state_nx = S_SEND;
      S_SEND:  if (w_last_hs) w_state_nx = S_GAP;
      S_GAP:   if (w_gap_done) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_trig_pend  <= 1'b0;
      r_slow_pend  <= 1'b0;
      r_rate_pend  <= 1'b0;
      r_slow_fill  <= '0;
      r_rate_delay <= '0;
      r_payload    <= '0;
      r_type       <= T_TRIG;
      r_idx        <= '0;
      r_gap_cnt    <= '0;
      r_frames     <= '0;
      r_drops      <= '0;
    end else begin
      r_trig_pend <= TrigReq || (r_trig_pend && !w_sel_trig);
      r_slow_pend <= SlowReq || (r_slow_pend && !w_sel_slow);
      r_rate_pend <= RateReq || (r_rate_pend && !w_sel_rate);
      if (SlowReq) r_slow_fill  <= SlowFill;
      if (RateReq) r_rate_delay <= RateDelay;
      r_drops <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

      if (w_sel_trig) begin
        r_type    <= T_TRIG;
        r_payload <= '0;
      end else if (w_sel_slow) begin
        r_type    <= T_SLOW;
        r_payload <= r_slow_fill;
      end else if (w_sel_rate) begin
        r_type    <= T_RATE;
        r_payload <= r_rate_delay;
      end

      if (w_sel_any)  r_idx <= '0;
      else if (w_hs)  r_idx <= r_idx + 3'd1;

      if (w_last_hs)              r_gap_cnt <= '0;
      else if (r_state == S_GAP)  r_gap_cnt <= r_gap_cnt + 8'd1;

      if (w_last_hs) r_frames <= r_frames + 16'd1;
    end
  end

  always_comb begin
    case (r_type)
      T_SLOW:  begin w_tag_hi = 16'h6C73; w_tag_lo = 32'h656D_776F; end
      T_RATE:  begin w_tag_hi = 16'h6172; w_tag_lo = 32'h6E69_6574; end
      default: begin w_tag_hi = 16'h7274; w_tag_lo = 32'h6E69_6769; end
    endcase
  end

  always_comb begin
    m_axis_tvalid = (r_state == S_SEND);
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    if (m_axis_tvalid) begin
      m_axis_tkeep = '1;
      m_axis_tlast = (r_idx == 3'd5);
      case (r_idx)
        3'd0:    m_axis_tdata = HDR0;
        3'd1:    m_axis_tdata = HDR1;
        3'd2:    m_axis_tdata = HDR2;
        3'd3:    m_axis_tdata = {w_tag_hi, ETH_TYPE};
        3'd4:    m_axis_tdata = w_tag_lo;
        default: m_axis_tdata = r_payload;
      endcase
    end
  end

  assign Busy       = (r_state != S_IDLE);
  assign FramesSent = r_frames;
  assign DropCount  = r_drops;

endmodule

// File: tb/tb_host_ctrl_packetizer.sv
// Directed bench for host_ctrl_packetizer: per-scenario tasks with hand-built frame tables.
module tb_host_ctrl_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        TrigReq = 1'b0, SlowReq = 1'b0, RateReq = 1'b0;
  logic [31:0] SlowFill = '0, RateDelay = '0;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, Busy;
  logic        tready = 1'b1;
  logic [15:0] FramesSent;
  logic [7:0]  DropCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_data [6];
  logic        cap_last [6];
  logic [3:0]  cap_keep [6];
  int          cap_n, cap_span, gap_before, stall_bad, zero_bad;

  always #5 clk = ~clk;

  host_ctrl_packetizer #(.GAP_CYCLES(4)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .TrigReq(TrigReq), .SlowReq(SlowReq), .SlowFill(SlowFill),
    .RateReq(RateReq), .RateDelay(RateDelay),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast), .m_axis_tready(tready),
    .Busy(Busy), .FramesSent(FramesSent), .DropCount(DropCount)
  );

  // Expected frame word: kind 0=trig, 1=slow, 2=rate
  function automatic logic [31:0] exp_word(input int kind, input int idx, input logic [31:0] pay);
    case (idx)
      0: return 32'h1111_6843;
      1: return 32'h1654_4502;
      2: return 32'h8F54_0000;
      3: return (kind == 0) ? 32'h7274_005C : (kind == 1) ? 32'h6C73_005C : 32'h6172_005C;
      4: return (kind == 0) ? 32'h6E69_6769 : (kind == 1) ? 32'h656D_776F : 32'h6E69_6574;
      default: return pay;
    endcase
  endfunction

  // Collects six handshaken words; returns at the negedge before the W5 handshake edge.
  task automatic cap_frame(input bit toggle);
    int cyc = 0;
    int first = -1;
    bit phase = 1'b1;
    bit stalled = 1'b0;
    logic [31:0] hold = '0;
    cap_n = 0; stall_bad = 0; zero_bad = 0; gap_before = 0; cap_span = 0;
    while (cap_n < 6 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stalled && (!tvalid || tdata !== hold)) stall_bad++;
      stalled = 1'b0;
      if (!tvalid) begin
        if (tdata !== 32'h0 || tkeep !== 4'h0 || tlast !== 1'b0) zero_bad++;
        if (cap_n == 0) gap_before++;
      end else begin
        tready = toggle ? phase : 1'b1;
        phase  = ~phase;
        if (tready) begin
          if (first < 0) first = cyc;
          cap_data[cap_n] = tdata;
          cap_last[cap_n] = tlast;
          cap_keep[cap_n] = tkeep;
          cap_n++;
          cap_span = cyc - first + 1;
        end else begin
          stalled = 1'b1;
          hold    = tdata;
        end
      end
    end
  endtask

  task automatic pulse(input bit t, input bit s, input logic [31:0] sf, input bit r, input logic [31:0] rd);
    @(negedge clk);
    TrigReq = t; SlowReq = s; RateReq = r;
    if (s) SlowFill = sf;
    if (r) RateDelay = rd;
    @(negedge clk);
    TrigReq = 1'b0; SlowReq = 1'b0; RateReq = 1'b0;
  endtask

  task automatic verify_frame(input string name, input int kind, input logic [31:0] pay);
    checks++;
    if (cap_n !== 6) begin
      errors++;
      $display("FAIL %s timeout: got %0d words, want 6", name, cap_n);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap_data[i] !== exp_word(kind, i, pay) || cap_keep[i] !== 4'hF || cap_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL %s W%0d: got %h keep %h last %b, want %h keep f last %b",
                 name, i, cap_data[i], cap_keep[i], cap_last[i], exp_word(kind, i, pay), (i == 5));
      end
    end
    checks++;
    if (zero_bad !== 0) begin
      errors++;
      $display("FAIL %s idle_zero: %0d idle cycles with nonzero data, want 0", name, zero_bad);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (tvalid !== 1'b0 || tdata !== '0 || tkeep !== '0 || tlast !== 1'b0 ||
        Busy !== 1'b0 || FramesSent !== '0 || DropCount !== '0) begin
      errors++;
      $display("FAIL reset_state: tvalid %b tdata %h tkeep %h tlast %b busy %b frames %h drops %h, want all 0",
               tvalid, tdata, tkeep, tlast, Busy, FramesSent, DropCount);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_trig;
    pulse(1'b1, 1'b0, '0, 1'b0, '0);
    cap_frame(1'b0);
    verify_frame("trig", 0, 32'h0);
    checks++;
    if (cap_span !== 6) begin
      errors++;
      $display("FAIL trig_span: got %0d cycles, want 6", cap_span);
    end
    @(negedge clk);
    checks++;
    if (FramesSent !== 16'd1 || Busy !== 1'b1 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL trig_done: frames %0d busy %b tvalid %b, want 1 1 0", FramesSent, Busy, tvalid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL trig_gap_end: busy %b, want 0", Busy);
    end
  endtask

  task automatic test_slow_rate;
    pulse(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h5);
    cap_frame(1'b0);
    verify_frame("slow", 1, 32'h0000_0200);
    cap_frame(1'b0);
    verify_frame("rate", 2, 32'h5);
    checks++;
    if (gap_before !== 5) begin
      errors++;
      $display("FAIL back_to_back_gap: got %0d idle cycles, want 5 (4 gap + 1 select)", gap_before);
    end
    @(negedge clk);
    checks++;
    if (FramesSent !== 16'd3) begin
      errors++;
      $display("FAIL slow_rate_frames: got %0d, want 3", FramesSent);
    end
  endtask

  task automatic test_stall;
    pulse(1'b0, 1'b0, '0, 1'b1, 32'h5);
    cap_frame(1'b1);
    verify_frame("stall_rate", 2, 32'h5);
    checks++;
    if (stall_bad !== 0) begin
      errors++;
      $display("FAIL stall_stable: %0d unstable stalls, want 0", stall_bad);
    end
    tready = 1'b1;
    @(negedge clk);
    checks++;
    if (FramesSent !== 16'd4) begin
      errors++;
      $display("FAIL stall_frames: got %0d, want 4", FramesSent);
    end
  endtask

  task automatic test_drop;
    int cyc = 0;
    repeat (6) @(negedge clk);
    tready = 1'b0;
    pulse(1'b1, 1'b0, '0, 1'b0, '0);
    while (!tvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    RateReq = 1'b1; RateDelay = 32'd1; @(negedge clk);
    RateDelay = 32'd2; @(negedge clk);
    RateDelay = 32'd3; @(negedge clk);
    RateReq = 1'b0;
    checks++;
    if (DropCount !== 8'd2) begin
      errors++;
      $display("FAIL drop_count: got %0d, want 2", DropCount);
    end
    cap_frame(1'b0);
    verify_frame("drop_trig", 0, 32'h0);
    cap_frame(1'b0);
    verify_frame("drop_rate", 2, 32'd3);
    @(negedge clk);
    checks++;
    if (FramesSent !== 16'd6 || DropCount !== 8'd2) begin
      errors++;
      $display("FAIL drop_after: frames %0d drops %0d, want 6 2", FramesSent, DropCount);
    end
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    int seen = 0;
    int late = 0;
    repeat (6) @(negedge clk);
    tready = 1'b1;
    pulse(1'b1, 1'b0, '0, 1'b0, '0);
    while (seen < 3 && cyc < 50) begin
      if (tvalid) seen++;
      if (seen < 3) @(negedge clk);
      cyc++;
    end
    checks++;
    if (tdata !== 32'h8F54_0000) begin
      errors++;
      $display("FAIL reset_mid_w2: got %h, want 8f540000", tdata);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tvalid !== 1'b0 || tdata !== '0 || tlast !== 1'b0 || Busy !== 1'b0 ||
        FramesSent !== '0 || DropCount !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: tvalid %b tdata %h tlast %b busy %b frames %0d drops %0d, want 0",
               tvalid, tdata, tlast, Busy, FramesSent, DropCount);
    end
    @(negedge clk);
    TrigReq = 1'b1; RateReq = 1'b1;
    @(negedge clk);
    TrigReq = 1'b0; RateReq = 1'b0;
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (tvalid) late++;
    end
    checks++;
    if (late !== 0 || FramesSent !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d valid cycles frames %0d, want 0 0", late, FramesSent);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.r_frames = 16'hFFFE;
    #1;
    release dut.r_frames;
    checks++;
    if (FramesSent !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_preset: got %h, want fffe", FramesSent);
    end
    pulse(1'b1, 1'b0, '0, 1'b0, '0);
    cap_frame(1'b0);
    @(negedge clk);
    checks++;
    if (FramesSent !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_ffff: got %h, want ffff", FramesSent);
    end
    pulse(1'b1, 1'b0, '0, 1'b0, '0);
    cap_frame(1'b0);
    verify_frame("wrap_trig", 0, 32'h0);
    @(negedge clk);
    checks++;
    if (FramesSent !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got %h, want 0000", FramesSent);
    end
  endtask

  initial begin
    test_reset;
    test_trig;
    test_slow_rate;
    test_stall;
    test_drop;
    test_reset_mid;
    test_wrap;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_ctrl_packetizer.md
HOST_CTRL_PACKETIZER -- requirements
Module: host_ctrl_packetizer

Interface
REQ-001 SHALL have parameter HDR0, default 32'h1111_6843: frame word 0.
REQ-002 SHALL have parameter HDR1, default 32'h1654_4502: frame word 1.
REQ-003 SHALL have parameter HDR2, default 32'h8F54_0000: frame word 2.
REQ-004 SHALL have parameter ETH_TYPE, default 16'h005C: low half of word 3.
REQ-005 SHALL have parameter GAP_CYCLES, default 4, range 1-255: idle cycles forced between frames.
REQ-006 SHALL have port m_axi_aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port m_axi_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port TrigReq, input, 1 bit: one-cycle pulse requesting a trigger ("trigin") frame.
REQ-009 SHALL have ports SlowReq (1 bit) and SlowFill (32 bits), inputs: slow-down ("slowme") request and its payload.
REQ-010 SHALL have ports RateReq (1 bit) and RateDelay (32 bits), inputs: rate-set ("ratein") request and its payload.
REQ-011 SHALL have ports m_axis_tdata (32 bits), m_axis_tkeep (4 bits), m_axis_tvalid (1 bit) and m_axis_tlast (1 bit), outputs: AXI-stream master toward the MAC transmit FIFO, with byte 0 = tdata[7:0].
REQ-012 SHALL have port m_axis_tready, input, 1 bit: AXI-stream ready.
REQ-013 SHALL have port Busy, output, 1 bit: high in SEND or GAP.
REQ-014 SHALL have port FramesSent, output, 16 bits: count of completed frames.
REQ-015 SHALL have port DropCount, output, 8 bits: count of overwritten pending requests.

Function
REQ-016 SHALL hold one pending flag per type (Trig, Slow, Rate); a request pulse sets the flag and captures the payload the same edge.
REQ-017 SHALL, on a pulse for a type already pending and not yet latched into a frame, overwrite the payload (latest wins), keep the flag set and increment DropCount, saturating at 8'hFF.
REQ-018 SHALL implement FSM states IDLE, SEND and GAP.
REQ-019 SHALL, in IDLE with any flag set, select by priority Trig > Slow > Rate, latch the type and payload, clear that flag, and enter SEND the next cycle; selection takes one cycle.
REQ-020 SHALL let a request arriving in the same cycle its flag is cleared by selection set the flag again for a later frame.
REQ-021 SHALL emit exactly 6 words: W0=HDR0, W1=HDR1, W2=HDR2, W3={tag_hi,ETH_TYPE}, W4=tag_lo, W5=payload.
REQ-022 SHALL use these tags: Trig hi 16'h7274, lo 32'h6E69_6769; Slow hi 16'h6C73, lo 32'h656D_776F; Rate hi 16'h6172, lo 32'h6E69_6574.
REQ-023 SHALL use payload 32'h0 for a Trig frame.
REQ-024 SHALL drive tkeep=4'hF for every word and tlast=1 only on W5.
REQ-025 SHALL assert tvalid throughout SEND; the word index advances only on tvalid&tready, and tdata/tlast hold stable while tready is low.
REQ-026 SHALL, on the W5 handshake, increment FramesSent (wrapping 16'hFFFF->0) and enter GAP.
REQ-027 SHALL hold tvalid low in GAP for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-028 SHALL keep an in-flight frame unaffected by new requests arriving during SEND; they are only queued.
REQ-029 SHALL drive tdata, tkeep and tlast to 0 whenever tvalid is 0.
REQ-030 SHALL allow a maximum throughput of one frame per 1+6+GAP_CYCLES cycles when tready is held high.

Reset
REQ-031 SHALL, on m_axi_aresetn low, immediately (asynchronously) force IDLE, clear all flags, payloads, FramesSent and DropCount, and drive tvalid, tlast, tdata, tkeep and Busy to 0.
REQ-032 SHALL abandon a frame interrupted by reset without tlast and never resume it.
REQ-033 SHALL ignore request pulses while reset is asserted.

Verification
REQ-034 SHALL pass: TrigReq pulse with tready=1 -> words 1111_6843, 1654_4502, 8F54_0000, 7274_005C, 6E69_6769, 0000_0000 on consecutive cycles, tlast on the 6th, FramesSent=1.
REQ-035 SHALL pass: SlowReq(SlowFill=32'h0000_0200) and RateReq(RateDelay=32'h5) in the same cycle -> Slow frame ending with W5=0000_0200, then GAP of 4 cycles, then Rate frame with W3=6172_005C and W5=0000_0005.
REQ-036 SHALL pass: tready toggled 1010... during a Rate frame -> 6 handshakes, data stable during stalls, frame matches the tready=1 frame exactly.
REQ-037 SHALL pass: RateReq payloads 1, 2, 3 pulsed while a Trig frame is in SEND -> one Rate frame with W5=3 and DropCount=2.
REQ-038 SHALL pass: reset asserted after the W2 handshake -> tvalid=0 the same cycle; after release with no requests, no further output and FramesSent=0.
REQ-039 SHALL pass: 65536 Trig frames -> FramesSent wraps to 0.
